// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO transceiver among NUM_REQ requesters.
// Optional watchdog: define MDIO_ARBITER_TIMEOUT_EN to enable the ARM/WAIT timeout.
module mdio_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [5*NUM_REQ-1:0]  req_md_addr,
    input  logic [5*NUM_REQ-1:0]  req_reg_addr,
    input  logic [16*NUM_REQ-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [NUM_REQ-1:0]    err,
    output logic [15:0]           rd_data,
    output logic [4:0]            phy_md_addr,
    output logic [4:0]            phy_reg_addr,
    output logic [15:0]           phy_wr_data,
    output logic                  phy_reg_wr,
    output logic                  phy_reg_rd,
    input  logic [15:0]           phy_rd_data,
    input  logic                  mgmt_busy
);

    localparam int            IW       = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [IW-1:0] last_grant_reg, last_grant_next;
    logic          wr_reg, wr_next;
    logic [4:0]    md_reg, md_next;
    logic [4:0]    reg_addr_reg, reg_addr_next;
    logic [15:0]   wr_data_reg, wr_data_next;
    logic [15:0]   rd_data_reg, rd_data_next;

    logic [4:0]    md_arr      [NUM_REQ];
    logic [4:0]    reg_arr     [NUM_REQ];
    logic [15:0]   wr_data_arr [NUM_REQ];

    logic          found_hi, found_lo;
    logic [IW-1:0] win_hi, win_lo, winner;
    logic          gnt_active, done_pulse, err_pulse;

`ifdef MDIO_ARBITER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic          tmo_reg, tmo_next;
`endif

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign md_arr[gi]      = req_md_addr[5*gi +: 5];
            assign reg_arr[gi]     = req_reg_addr[5*gi +: 5];
            assign wr_data_arr[gi] = req_wr_data[16*gi +: 16];
            assign gnt[gi]         = gnt_active & (idx_reg == IW'(gi));
            assign done[gi]        = done_pulse & (idx_reg == IW'(gi));
`ifdef MDIO_ARBITER_TIMEOUT_EN
            assign err[gi]         = err_pulse & (idx_reg == IW'(gi));
`endif
        end
    endgenerate

`ifndef MDIO_ARBITER_TIMEOUT_EN
    assign err = '0;
`endif

    // Round robin: lowest requesting index above last_grant, else lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_lo = 1'b1;
                win_lo   = IW'(i);
                if (IW'(i) > last_grant_reg) begin
                    found_hi = 1'b1;
                    win_hi   = IW'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        last_grant_next = last_grant_reg;
        wr_next         = wr_reg;
        md_next         = md_reg;
        reg_addr_next   = reg_addr_reg;
        wr_data_next    = wr_data_reg;
        rd_data_next    = rd_data_reg;
`ifdef MDIO_ARBITER_TIMEOUT_EN
        tmo_cnt_next    = tmo_cnt_reg;
        tmo_next        = tmo_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (found_lo && !mgmt_busy) begin
                    idx_next      = winner;
                    wr_next       = req_wr[winner];
                    md_next       = md_arr[winner];
                    reg_addr_next = reg_arr[winner];
                    wr_data_next  = wr_data_arr[winner];
                    state_next    = ST_ISSUE;
`ifdef MDIO_ARBITER_TIMEOUT_EN
                    tmo_cnt_next  = '0;
                    tmo_next      = 1'b0;
`endif
                end
            end
            ST_ISSUE: state_next = ST_ARM;
            ST_ARM: begin
                if (mgmt_busy) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mgmt_busy) begin
                    if (!wr_reg) rd_data_next = phy_rd_data;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                last_grant_next = idx_reg;
                state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
`ifdef MDIO_ARBITER_TIMEOUT_EN
        // The watchdog overrides a completion landing in the same cycle.
        if (state_reg == ST_ARM || state_reg == ST_WAIT) begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
            if (tmo_cnt_next >= CW'(TIMEOUT_CYCLES)) begin
                tmo_next     = 1'b1;
                rd_data_next = 16'hFFFF;
                state_next   = ST_DONE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            last_grant_reg <= LAST_IDX;
            wr_reg         <= 1'b0;
            md_reg         <= '0;
            reg_addr_reg   <= '0;
            wr_data_reg    <= '0;
            rd_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            last_grant_reg <= last_grant_next;
            wr_reg         <= wr_next;
            md_reg         <= md_next;
            reg_addr_reg   <= reg_addr_next;
            wr_data_reg    <= wr_data_next;
            rd_data_reg    <= rd_data_next;
        end
    end

`ifdef MDIO_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= '0;
            tmo_reg     <= 1'b0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
            tmo_reg     <= tmo_next;
        end
    end
    assign err_pulse  = (state_reg == ST_DONE) & tmo_reg;
    assign done_pulse = (state_reg == ST_DONE) & ~tmo_reg;
`else
    assign err_pulse  = 1'b0;
    assign done_pulse = (state_reg == ST_DONE);
`endif

    assign gnt_active   = (state_reg != ST_IDLE);
    assign phy_reg_wr   = (state_reg == ST_ISSUE) & wr_reg;
    assign phy_reg_rd   = (state_reg == ST_ISSUE) & ~wr_reg;
    assign phy_md_addr  = md_reg;
    assign phy_reg_addr = reg_addr_reg;
    assign phy_wr_data  = wr_data_reg;
    assign rd_data      = rd_data_reg;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter: behavioural PHY, round-robin reference, random traffic.
module tb_mdio_arbiter;
    localparam int N   = 2;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = '0, req_wr = '0;
    logic [9:0]    req_md_addr = '0, req_reg_addr = '0;
    logic [31:0]   req_wr_data = '0;
    logic [1:0]    gnt, done, err;
    logic [15:0]   rd_data, phy_wr_data, phy_rd_data;
    logic [4:0]    phy_md_addr, phy_reg_addr;
    logic          phy_reg_wr, phy_reg_rd, mgmt_busy;

    int n_cmp = 0, n_bad = 0;

    // PHY register contents and behaviour knobs
    logic [15:0] phy_mem [32][32];
    int          phy_busy_len = 5, phy_rise_dly = 1;
    bit          phy_stuck = 1'b0;
    int          rise_cnt, busy_cnt;

    // Requester transactions and reference state
    logic        t_wr [N];
    logic [4:0]  t_md [N], t_reg [N];
    logic [15:0] t_data [N];
    int          ref_last;
    logic [15:0] exp_rd;

    // Per-transaction capture
    bit          cap_got;
    int          cap_cyc, cap_scyc, cap_nrd, cap_nwr;
    logic [1:0]  cap_gnt, cap_done, cap_err;
    logic [4:0]  cap_md, cap_reg;
    logic [15:0] cap_wdata, cap_rd;
    logic        cap_wr;

    always #5 clk = ~clk;

    mdio_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
        .req_md_addr(req_md_addr), .req_reg_addr(req_reg_addr), .req_wr_data(req_wr_data),
        .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
        .phy_md_addr(phy_md_addr), .phy_reg_addr(phy_reg_addr), .phy_wr_data(phy_wr_data),
        .phy_reg_wr(phy_reg_wr), .phy_reg_rd(phy_reg_rd),
        .phy_rd_data(phy_rd_data), .mgmt_busy(mgmt_busy)
    );

    // Transceiver model: busy rises phy_rise_dly edges after a strobe, lasts phy_busy_len cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mgmt_busy   <= 1'b0;
            rise_cnt    <= 0;
            busy_cnt    <= 0;
            phy_rd_data <= 16'hDEAD;
        end else if (phy_reg_rd || phy_reg_wr) begin
            rise_cnt    <= phy_rise_dly;
            busy_cnt    <= phy_busy_len;
            phy_rd_data <= phy_reg_rd ? phy_mem[phy_md_addr][phy_reg_addr] : 16'hDEAD;
        end else if (rise_cnt != 0) begin
            rise_cnt <= rise_cnt - 1;
            if (rise_cnt == 1) mgmt_busy <= 1'b1;
        end else if (mgmt_busy && !phy_stuck) begin
            if (busy_cnt <= 1) mgmt_busy <= 1'b0;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    // Invariants checked whenever a strobe or completion is visible
    initial forever begin
        @(negedge clk);
        if (rst_n && (phy_reg_rd || phy_reg_wr || (|done) || (|err))) begin
            n_cmp++;
            if ($countones(gnt) > 1 || $countones(done) > 1 || $countones(err) > 1 ||
                ((|done) && (|err)) || (phy_reg_rd && phy_reg_wr)) begin
                n_bad++;
                $display("FAIL onehot: gnt=%b done=%b err=%b wr=%b rd=%b", gnt, done, err, phy_reg_wr, phy_reg_rd);
            end
            n_cmp++;
            if ((phy_reg_rd || phy_reg_wr) && mgmt_busy !== 1'b0) begin
                n_bad++;
                $display("FAIL strobe_busy: busy=%b required 0", mgmt_busy);
            end else if (((|done) || (|err)) && gnt !== (done | err)) begin
                n_bad++;
                $display("FAIL gnt_at_done: gnt=%b required %b", gnt, done | err);
            end
        end
    end

    function automatic int next_grant(input int last, input logic [1:0] m);
        next_grant = -1;
        for (int off = N; off >= 1; off--) begin
            if (m[(last + off) % N]) next_grant = (last + off) % N;
        end
    endfunction

    task automatic set_txn(input int i, input logic w, input logic [4:0] m, input logic [4:0] r, input logic [15:0] d);
        t_wr[i] = w; t_md[i] = m; t_reg[i] = r; t_data[i] = d;
        req_wr[i] = w;
        req_md_addr[5*i +: 5]   = m;
        req_reg_addr[5*i +: 5]  = r;
        req_wr_data[16*i +: 16] = d;
    endtask

    // Runs until a done/err pulse (or budget); optionally drops req bits after drop_after busy cycles
    task automatic wait_cpl(input int budget, input int drop_after, input logic [1:0] drop_mask);
        int busy_seen;
        busy_seen = 0; cap_got = 0; cap_nrd = 0; cap_nwr = 0; cap_scyc = -1; cap_cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (phy_reg_rd) cap_nrd++;
            if (phy_reg_wr) cap_nwr++;
            if (phy_reg_rd || phy_reg_wr) begin
                cap_scyc = c; cap_gnt = gnt; cap_md = phy_md_addr; cap_reg = phy_reg_addr;
                cap_wdata = phy_wr_data; cap_wr = phy_reg_wr;
            end
            if (mgmt_busy) begin
                busy_seen++;
                if (busy_seen == drop_after) req = req & ~drop_mask;
            end
            if ((|done) || (|err)) begin
                cap_got = 1; cap_cyc = c; cap_done = done; cap_err = err; cap_rd = rd_data;
                break;
            end
        end
        if (!cap_got) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no done/err within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        for (int m = 0; m < 32; m++)
            for (int r = 0; r < 32; r++)
                phy_mem[m][r] = {5'(m), 5'(r), 6'(m ^ (r * 3))};
        rst_n = 1'b0; req = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL rst_gnt: %b required 00", gnt); end
        n_cmp++; if (done !== 2'b00 || err !== 2'b00) begin n_bad++; $display("FAIL rst_done_err: %b/%b required 00/00", done, err); end
        n_cmp++; if ({phy_reg_wr, phy_reg_rd} !== 2'b00) begin n_bad++; $display("FAIL rst_strobe: %b required 00", {phy_reg_wr, phy_reg_rd}); end
        n_cmp++; if ({phy_md_addr, phy_reg_addr, phy_wr_data} !== 26'h0) begin n_bad++; $display("FAIL rst_phy: %h required 0", {phy_md_addr, phy_reg_addr, phy_wr_data}); end
        n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL rst_rd_data: %h required 0000", rd_data); end
        rst_n = 1'b1; ref_last = N - 1; exp_rd = 16'h0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        phy_mem[1][2] = 16'h0141; phy_busy_len = 40; phy_rise_dly = 1;
        set_txn(0, 1'b0, 5'h01, 5'h02, 16'h5555);
        req[0] = 1'b1;
        wait_cpl(500, 0, 2'b00);
        req[0] = 1'b0;
        if (cap_got) begin
            exp_rd = 16'h0141; ref_last = 0;
            n_cmp++; if (cap_nrd != 1 || cap_nwr != 0) begin n_bad++; $display("FAIL rd_strobes: rd=%0d wr=%0d required 1/0", cap_nrd, cap_nwr); end
            n_cmp++; if ({cap_md, cap_reg} !== {5'h01, 5'h02}) begin n_bad++; $display("FAIL rd_addr: %h/%h required 01/02", cap_md, cap_reg); end
            n_cmp++; if (cap_done !== 2'b01) begin n_bad++; $display("FAIL rd_done: %b required 01", cap_done); end
            n_cmp++; if (cap_rd !== 16'h0141) begin n_bad++; $display("FAIL rd_data: %h required 0141", cap_rd); end
            n_cmp++; if (cap_cyc < 44) begin n_bad++; $display("FAIL rd_latency: %0d required >= 44", cap_cyc); end
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL rd_extra_done: %b required 00", done); end
        end
    endtask

    task automatic test_write();
        phy_busy_len = 10;
        set_txn(1, 1'b1, 5'h03, 5'h00, 16'h8000);
        req[1] = 1'b1;
        wait_cpl(500, 0, 2'b00);
        req[1] = 1'b0;
        if (cap_got) begin
            phy_mem[3][0] = 16'h8000; ref_last = 1;
            n_cmp++; if (cap_nwr != 1 || cap_nrd != 0) begin n_bad++; $display("FAIL wr_strobes: wr=%0d rd=%0d required 1/0", cap_nwr, cap_nrd); end
            n_cmp++; if (cap_wdata !== 16'h8000 || cap_reg !== 5'h00) begin n_bad++; $display("FAIL wr_fields: %h/%h required 8000/00", cap_wdata, cap_reg); end
            n_cmp++; if (cap_gnt !== 2'b10 || cap_done !== 2'b10) begin n_bad++; $display("FAIL wr_gnt_done: %b/%b required 10/10", cap_gnt, cap_done); end
            n_cmp++; if (cap_rd !== exp_rd) begin n_bad++; $display("FAIL wr_rd_data: %h required %h", cap_rd, exp_rd); end
        end
    endtask

    task automatic test_contention();
        int e;
        phy_busy_len = 6;
        set_txn(0, 1'b0, 5'h04, 5'h01, 16'h0);
        set_txn(1, 1'b0, 5'h05, 5'h03, 16'h0);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_cpl(300, 0, 2'b00);
            if (k == 3) req = 2'b00;
            if (!cap_got) break;
            e = next_grant(ref_last, 2'b11);
            exp_rd = phy_mem[t_md[e]][t_reg[e]];
            n_cmp++; if (cap_gnt !== 2'(1 << e) || cap_done !== 2'(1 << e)) begin n_bad++; $display("FAIL cont_order%0d: gnt=%b done=%b required idx %0d", k, cap_gnt, cap_done, e); end
            n_cmp++; if (cap_nrd != 1 || cap_nwr != 0) begin n_bad++; $display("FAIL cont_strobes%0d: rd=%0d wr=%0d required 1/0", k, cap_nrd, cap_nwr); end
            n_cmp++; if (cap_rd !== exp_rd) begin n_bad++; $display("FAIL cont_rd%0d: %h required %h", k, cap_rd, exp_rd); end
            ref_last = e;
        end
    endtask

    task automatic test_mid_drop();
        phy_mem[2][7] = 16'hABCD; phy_busy_len = 20;
        set_txn(0, 1'b0, 5'h02, 5'h07, 16'h0);
        req[0] = 1'b1;
        wait_cpl(300, 5, 2'b01);
        req[0] = 1'b0;
        if (cap_got) begin
            exp_rd = 16'hABCD; ref_last = 0;
            n_cmp++; if (cap_done !== 2'b01) begin n_bad++; $display("FAIL drop_done: %b required 01", cap_done); end
            n_cmp++; if (cap_rd !== 16'hABCD) begin n_bad++; $display("FAIL drop_rd: %h required abcd", cap_rd); end
        end
    endtask

    task automatic test_reset_mid();
        int busy_seen, spurious;
        phy_busy_len = 50; busy_seen = 0; spurious = 0;
        set_txn(0, 1'b0, 5'h06, 5'h06, 16'h0);
        req[0] = 1'b1;
        for (int c = 0; c < 100 && busy_seen < 5; c++) begin
            @(negedge clk);
            if (mgmt_busy) busy_seen++;
        end
        n_cmp++; if (busy_seen < 5) begin n_bad++; $display("FAIL rmid_busy: %0d busy cycles required 5", busy_seen); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({gnt, done, err, phy_reg_wr, phy_reg_rd} !== 8'h0) begin n_bad++; $display("FAIL rmid_ctrl: %b required 0", {gnt, done, err, phy_reg_wr, phy_reg_rd}); end
        n_cmp++; if ({phy_md_addr, phy_reg_addr, phy_wr_data, rd_data} !== 42'h0) begin n_bad++; $display("FAIL rmid_data: %h required 0", {phy_md_addr, phy_reg_addr, phy_wr_data, rd_data}); end
        req = 2'b00; exp_rd = 16'h0; ref_last = N - 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if ((|done) || (|err)) spurious++;
        end
        n_cmp++; if (spurious != 0) begin n_bad++; $display("FAIL rmid_no_done: %0d pulses required 0", spurious); end
        phy_busy_len = 4;
        set_txn(1, 1'b0, 5'h07, 5'h01, 16'h0);
        req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            wait_cpl(200, 0, 2'b00);
            req[k] = 1'b0;
            if (!cap_got) break;
            exp_rd = phy_mem[t_md[k]][t_reg[k]]; ref_last = k;
            n_cmp++; if (cap_done !== 2'(1 << k)) begin n_bad++; $display("FAIL rmid_first%0d: %b required idx %0d", k, cap_done, k); end
            n_cmp++; if (cap_rd !== exp_rd) begin n_bad++; $display("FAIL rmid_rd%0d: %h required %h", k, cap_rd, exp_rd); end
        end
    endtask

    task automatic test_random();
        int e;
        for (int i = 0; i < N; i++)
            set_txn(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom));
        req = 2'b11;
        for (int k = 0; k < 20; k++) begin
            phy_busy_len = $urandom_range(1, 30); phy_rise_dly = $urandom_range(1, 2);
            wait_cpl(300, 0, 2'b00);
            if (!cap_got) break;
            e = next_grant(ref_last, 2'b11);
            if (!t_wr[e]) exp_rd = phy_mem[t_md[e]][t_reg[e]];
            n_cmp++; if (cap_gnt !== 2'(1 << e) || cap_done !== 2'(1 << e)) begin n_bad++; $display("FAIL rnd_grant%0d: gnt=%b done=%b required idx %0d", k, cap_gnt, cap_done, e); end
            n_cmp++; if (cap_nrd + cap_nwr != 1 || cap_wr !== t_wr[e]) begin n_bad++; $display("FAIL rnd_strobe%0d: rd=%0d wr=%0d required wr=%b", k, cap_nrd, cap_nwr, t_wr[e]); end
            n_cmp++; if ({cap_md, cap_reg} !== {t_md[e], t_reg[e]}) begin n_bad++; $display("FAIL rnd_addr%0d: %h/%h required %h/%h", k, cap_md, cap_reg, t_md[e], t_reg[e]); end
            n_cmp++; if (t_wr[e] && cap_wdata !== t_data[e]) begin n_bad++; $display("FAIL rnd_wdata%0d: %h required %h", k, cap_wdata, t_data[e]); end
            n_cmp++; if (cap_rd !== exp_rd) begin n_bad++; $display("FAIL rnd_rd%0d: %h required %h", k, cap_rd, exp_rd); end
            if (t_wr[e]) phy_mem[t_md[e]][t_reg[e]] = t_data[e];
            ref_last = e;
            set_txn(e, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom));
        end
        req = 2'b00;
        phy_rise_dly = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stuck();
        phy_busy_len = 3; phy_stuck = 1'b1;
        set_txn(0, 1'b0, 5'h01, 5'h02, 16'h0);
        req[0] = 1'b1;
`ifdef MDIO_ARBITER_TIMEOUT_EN
        wait_cpl(400, 0, 2'b00);
        req[0] = 1'b0;
        if (cap_got) begin
            n_cmp++; if (cap_err !== 2'b01 || cap_done !== 2'b00) begin n_bad++; $display("FAIL tmo_err: err=%b done=%b required 01/00", cap_err, cap_done); end
            n_cmp++; if (cap_rd !== 16'hFFFF) begin n_bad++; $display("FAIL tmo_rd: %h required ffff", cap_rd); end
            n_cmp++; if (cap_cyc - cap_scyc < TMO - 1 || cap_cyc - cap_scyc > TMO + 1) begin n_bad++; $display("FAIL tmo_latency: %0d required %0d", cap_cyc - cap_scyc, TMO); end
        end
        phy_stuck = 1'b0;
        set_txn(1, 1'b0, 5'h09, 5'h04, 16'h0);
        req[1] = 1'b1;
        wait_cpl(200, 0, 2'b00);
        req[1] = 1'b0;
        if (cap_got) begin
            n_cmp++; if (cap_done !== 2'b10 || cap_rd !== phy_mem[9][4]) begin n_bad++; $display("FAIL tmo_next: done=%b rd=%h required 10/%h", cap_done, cap_rd, phy_mem[9][4]); end
        end
`else
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 10000; c++) begin
                @(negedge clk);
                if ((|done) || (|err)) pulses++;
            end
            n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL stuck_pulses: %0d required 0", pulses); end
            n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL stuck_gnt: %b required 01", gnt); end
            phy_stuck = 1'b0;
            wait_cpl(100, 0, 2'b00);
            req[0] = 1'b0;
            if (cap_got) begin
                n_cmp++; if (cap_done !== 2'b01 || cap_rd !== phy_mem[1][2]) begin n_bad++; $display("FAIL stuck_release: done=%b rd=%h required 01/%h", cap_done, cap_rd, phy_mem[1][2]); end
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_mid_drop();
        test_reset_mid();
        test_random();
        test_stuck();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one EthernetMDIOTransceiver (range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 20'hFFFFF, watchdog limit in clk cycles (used only when the timeout feature is compiled in).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  NUM_REQ  per-requester transaction request, level; held until matching done/err.
REQ-006 req_wr  input  NUM_REQ  1 = write, 0 = read, per requester.
REQ-007 req_md_addr  input  5*NUM_REQ  PHY address, requester i at bits [5i+4:5i].
REQ-008 req_reg_addr  input  5*NUM_REQ  register address, requester i at bits [5i+4:5i].
REQ-009 req_wr_data  input  16*NUM_REQ  write data, requester i at bits [16i+15:16i].
REQ-010 gnt  output  NUM_REQ  one-hot, high for granted requester from ISSUE through DONE inclusive.
REQ-011 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 err  output  NUM_REQ  one-cycle timeout pulse to the granted requester.
REQ-013 rd_data  output  16  read result, valid in the done/err cycle, held until next completion.
REQ-014 phy_md_addr, phy_reg_addr  output  5 each  to transceiver; driven from the granted requester, held from ISSUE until return to IDLE.
REQ-015 phy_wr_data  output  16  to transceiver; same hold rule.
REQ-016 phy_reg_wr, phy_reg_rd  output  1 each  one-cycle strobes to transceiver.
REQ-017 phy_rd_data  input  16  from transceiver, sampled when mgmt_busy falls.
REQ-018 mgmt_busy  input  1  transceiver busy, asserted by the transceiver within 2 cycles of a strobe.

Function
REQ-019 States: IDLE, ISSUE, ARM, WAIT, DONE.
REQ-020 IDLE: if any req bit high, select winner round-robin starting at index last_grant+1 mod NUM_REQ, latch index, go ISSUE next cycle; else stay.
REQ-021 ISSUE: assert exactly one of phy_reg_wr/phy_reg_rd per latched req_wr for exactly one cycle; go ARM.
REQ-022 ARM: stay until mgmt_busy=1, then go WAIT.
REQ-023 WAIT: stay while mgmt_busy=1; on mgmt_busy=0 capture phy_rd_data (reads only; writes leave rd_data unchanged), go DONE.
REQ-024 DONE: pulse done[idx] one cycle, update last_grant=idx, go IDLE; minimum request-to-done latency 5 cycles.
REQ-025 Request fields are sampled once at IDLE->ISSUE; later changes, including req deassertion, do not abort the transaction.
REQ-026 A requester holding req after done is re-arbitrated normally; with all requesters active, grants rotate strictly 0,1,..,NUM_REQ-1,0.
REQ-027 Simultaneous new requests in IDLE: only one granted; others wait, none dropped.
REQ-028 gnt, done, err never have more than one bit set; done and err never both high.
REQ-029 Strobes never issued while mgmt_busy=1 in IDLE; IDLE waits for mgmt_busy=0 before granting.

Reset
REQ-030 On rst_n low, immediately: state IDLE, gnt/done/err=0, phy_reg_wr/phy_reg_rd=0, phy_* address/data=0, rd_data=0, last_grant=NUM_REQ-1, timeout counter=0.
REQ-031 Reset mid-transaction abandons it with no done/err pulse; first post-reset grant goes to requester 0 if requesting.

Configuration
REQ-032 Macro MDIO_ARBITER_TIMEOUT_EN: when defined, a counter clears on ISSUE and increments each cycle in ARM/WAIT; reaching TIMEOUT_CYCLES forces DONE with err[idx] pulse instead of done, rd_data=16'hFFFF.
REQ-033 Without MDIO_ARBITER_TIMEOUT_EN: no counter, ARM/WAIT wait indefinitely, err tied to 0.

Verification
REQ-034 Single read: req[0]=1, md=5'h01, reg=5'h02, model returns 16'h0141 after 40 busy cycles -> one phy_reg_rd pulse, done[0] once, rd_data=16'h0141.
REQ-035 Write: req[1]=1, wr=1, reg=5'h00, data=16'h8000 -> one phy_reg_wr pulse with phy_wr_data=16'h8000, done[1], rd_data unchanged.
REQ-036 Contention: req=2'b11 held for 4 transactions -> grant order 0,1,0,1, no overlapping strobes.
REQ-037 Mid-transaction: drop req[0] while WAIT -> transaction completes, done[0] pulses; reassert rst_n low during WAIT -> outputs zero, no done.
REQ-038 With MDIO_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=100, busy stuck high -> err[0] at cycle 100 after ISSUE, rd_data=16'hFFFF, next request served.
REQ-039 Without macro, busy stuck high 10000 cycles -> no done/err, gnt held.
